uart_rx: RTL
============

Name: uart_rx

Overview:
- Serial receiver for the FPGA-to-host UART link: 8 data bits, LSB first, one start bit, one stop bit, no parity by default.
- Runtime-programmable baud rate; the divisor is derived from a clock-frequency parameter and the `baudrate` input.
- Counterpart of the existing UART transmitter. Feeds received bytes to the command/register decoder as one-cycle valid strobes.

Parameters:
- CLK_FREQ_HZ, 16_000_000, frequency of i_Clock in Hz; clocks per bit = CLK_FREQ_HZ/baudrate (integer division).

Ports:
- i_Clock  input  1  system clock, all logic on rising edge
- i_Reset  input  1  asynchronous, active-high reset
- baudrate  input  32  baud rate in bits/s; latched at start-bit detection
- i_Rx_Serial  input  1  asynchronous serial line, idle high
- o_Rx_DV  output  1  one-cycle strobe, o_Rx_Byte valid
- o_Rx_Byte  output  8  last correctly framed byte; held until next valid byte
- o_Rx_Active  output  1  high from start-bit detection until return to IDLE
- o_Rx_Frame_Err  output  1  one-cycle strobe, stop bit sampled low

Behaviour:
- Reset: every output is 0. Synchronizer flops reset to 1 (idle line). State is IDLE and all counters are 0.
- Input synchronizer:
  - i_Rx_Serial passes through 2 flops; all decisions use the second flop (rx_s).
  - Total input latency is 2 cycles.
- CLKS: CLK_FREQ_HZ/baudrate, computed once on entry to START and registered in r_Clks.
  - baudrate == 0, or a resulting CLKS < 4: the block stays in IDLE and ignores the line.
- IDLE:
  - Bit index and clock count are cleared.
  - rx_s == 0 → latch r_Clks, assert o_Rx_Active, go to START.
- START:
  - Count from 0 to (r_Clks-1)/2.
  - At that count, sample rx_s:
    - 0 → clear count, go to DATA.
    - 1 → glitch: go to IDLE, drop o_Rx_Active, no strobe.
- DATA:
  - Count 0..r_Clks-1; at r_Clks-1, shift rx_s into bit[r_Bit_Index] and clear the count.
  - After bit index 7, go to STOP; otherwise increment the index.
  - Each data sample therefore lands mid-bit.
- STOP:
  - Count 0..r_Clks-1, then sample rx_s.
  - rx_s == 1 → load o_Rx_Byte and pulse o_Rx_DV for exactly one cycle, go to CLEANUP.
  - rx_s == 0 → pulse o_Rx_Frame_Err for one cycle, leave o_Rx_Byte unchanged, go to WAIT_IDLE.
- WAIT_IDLE: remain until rx_s == 1, so a break condition produces exactly one error strobe; then go to CLEANUP.
- CLEANUP: one cycle, deassert o_Rx_Active, go to IDLE.
- Output relationships:
  - o_Rx_DV and o_Rx_Frame_Err are never high in the same cycle.
  - At most one strobe per frame.
- Timing:
  - A new start bit is recognised no earlier than the cycle after CLEANUP.
  - Back-to-back frames at the nominal rate are received without loss, because the stop sample lands mid-stop-bit.
- Changing baudrate mid-frame has no effect until the next start bit.
- Asserting i_Reset mid-frame immediately returns all state and outputs to reset values; the partial byte is discarded.
- Tolerance: ±3% baud mismatch must still decode correctly for CLKS ≥ 16.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds input i_Parity_Odd (1 bit, sampled at start detection) and output o_Rx_Parity_Err (1-cycle strobe).
  - A PARITY state sits between DATA and STOP and samples one extra bit at mid-bit.
  - Expected parity is the XOR of the 8 data bits, inverted when i_Parity_Odd = 1.
  - Parity mismatch with a good stop bit → o_Rx_Parity_Err pulses in the same cycle o_Rx_DV would have pulsed. o_Rx_DV stays low and o_Rx_Byte is unchanged.
  - A framing error takes precedence over a parity error.
- Undefined: no parity port or state exists; frame = 10 bits.

Test Plan:
(CLK_FREQ_HZ=16_000_000 and baudrate=1_000_000, so CLKS=16, unless stated otherwise.)
- Reset then idle line for 100 cycles → all outputs 0, o_Rx_Active 0.
- Send 0xA5 → a single o_Rx_DV pulse with o_Rx_Byte=0xA5, asserted 2+7+8·16+16+1 = 154 cycles (±1) after the line falls.
- Send 0x00, 0xFF, 0x3C back to back at 16 clocks/bit → three DV pulses with bytes in order, no Frame_Err.
- Low glitch of 5 cycles on idle line → o_Rx_Active rises then falls, no strobe of any kind.
- Frame 0x55 with stop bit forced low, line held low for 400 cycles, then high → exactly one o_Rx_Frame_Err pulse, o_Rx_Byte keeps its previous value. A following 0x12 frame decodes correctly.
- baudrate=115_200 (CLKS=138), sender at 118_656 baud (+3%) sending 0xC3 → o_Rx_DV pulse with 0xC3. Assert i_Reset at bit 4 of a second frame → outputs return to 0 asynchronously and the next full frame decodes normally.

Source files
------------

// File: rtl/uart_rx_if.sv
// ---------------------------------------------------------------------------
// uart_rx_if
//
// Purpose : bundles the serial line, the baud-rate setting and the received
//           byte strobes of the UART receiver into one interface.
//
// Signals :
//   baudrate        line rate in bits/s, latched by the receiver at start-bit
//   i_Rx_Serial     asynchronous serial line, idle high
//   o_Rx_DV         one-cycle strobe, o_Rx_Byte valid
//   o_Rx_Byte       last correctly framed byte
//   o_Rx_Active     receiver busy with a frame
//   o_Rx_Frame_Err  one-cycle strobe, stop bit sampled low
//   i_Parity_Odd    (UART_RX_PARITY_EN only) 1 = odd parity, 0 = even
//   o_Rx_Parity_Err (UART_RX_PARITY_EN only) one-cycle strobe, parity mismatch
//
// Modports:
//   master : the side driving the line and rate (host / testbench)
//   slave  : the receiver itself
//
// Build option: define UART_RX_PARITY_EN to add the parity signals.
// ---------------------------------------------------------------------------
interface uart_rx_if;
    logic [31:0] baudrate;
    logic        i_Rx_Serial;
    logic        o_Rx_DV;
    logic [7:0]  o_Rx_Byte;
    logic        o_Rx_Active;
    logic        o_Rx_Frame_Err;
`ifdef UART_RX_PARITY_EN
    logic        i_Parity_Odd;
    logic        o_Rx_Parity_Err;
`endif

    modport master (
        output baudrate,
        output i_Rx_Serial,
`ifdef UART_RX_PARITY_EN
        output i_Parity_Odd,
        input  o_Rx_Parity_Err,
`endif
        input  o_Rx_DV,
        input  o_Rx_Byte,
        input  o_Rx_Active,
        input  o_Rx_Frame_Err
    );

    modport slave (
        input  baudrate,
        input  i_Rx_Serial,
`ifdef UART_RX_PARITY_EN
        input  i_Parity_Odd,
        output o_Rx_Parity_Err,
`endif
        output o_Rx_DV,
        output o_Rx_Byte,
        output o_Rx_Active,
        output o_Rx_Frame_Err
    );
endinterface : uart_rx_if

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
//
// Purpose : 8N1 UART receiver (8 data bits LSB first, 1 start, 1 stop) with a
//           runtime baud rate. Clocks per bit = CLK_FREQ_HZ / baudrate,
//           captured when a start bit is detected. Received bytes leave as
//           one-cycle valid strobes for the command/register decoder.
//
// Ports   :
//   i_Clock  system clock, rising edge
//   i_Reset  asynchronous, active-high reset
//   rx_if    uart_rx_if.slave: baudrate, i_Rx_Serial in; o_Rx_DV, o_Rx_Byte,
//            o_Rx_Active, o_Rx_Frame_Err out
//
// Build option: define UART_RX_PARITY_EN to add a parity bit between the
//   data and stop bits (i_Parity_Odd selects odd parity, o_Rx_Parity_Err
//   strobes on mismatch). Without it the frame is 10 bits.
// ---------------------------------------------------------------------------
module uart_rx #(
    parameter int CLK_FREQ_HZ = 16_000_000
) (
    input logic     i_Clock,
    input logic     i_Reset,
    uart_rx_if.slave rx_if
);

    localparam logic [31:0] CLK_FREQ  = 32'(CLK_FREQ_HZ);
    // Shortest bit period that still leaves room for a mid-bit sample.
    localparam logic [31:0] MIN_CLKS  = 32'd4;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] DATA      = 3'd2;
    localparam logic [2:0] PARITY    = 3'd3;
    localparam logic [2:0] STOP      = 3'd4;
    localparam logic [2:0] WAIT_IDLE = 3'd5;
    localparam logic [2:0] CLEANUP   = 3'd6;

    // Two-flop synchronizer; rx_s is the only view of the line the FSM uses.
    logic [1:0]  sync_q;
    logic        rx_s;

    logic [2:0]  state_q,  state_d;
    logic [31:0] cnt_q,    cnt_d;
    logic [31:0] clks_q,   clks_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q,  shift_d;
    logic [7:0]  byte_q,   byte_d;
    logic        dv_q,     dv_d;
    logic        fe_q,     fe_d;
    logic        active_q, active_d;

    logic [31:0] clks_calc;
    logic [31:0] half_clks;
    logic        bit_end;
    logic        frame_ok;

`ifdef UART_RX_PARITY_EN
    logic        par_odd_q, par_odd_d;
    logic        par_bit_q, par_bit_d;
    logic        perr_q,    perr_d;
`endif

    assign rx_s = sync_q[1];

    // Divider output is only trusted when baudrate is non-zero; a zero or
    // too-fast rate yields a value below MIN_CLKS and keeps the FSM in IDLE.
    assign clks_calc = (rx_if.baudrate == 32'd0) ? 32'd0 : CLK_FREQ / rx_if.baudrate;
    assign half_clks = (clks_q - 32'd1) >> 1;
    assign bit_end   = (cnt_q == clks_q - 32'd1);

`ifdef UART_RX_PARITY_EN
    // Expected parity bit: even parity over the data, inverted for odd.
    assign frame_ok = (par_bit_q == ((^shift_q) ^ par_odd_q));
`else
    assign frame_ok = 1'b1;
`endif

    // NOTE: every variable gets a default at the top of the block so no path
    // leaves it unassigned; this is what keeps the combinational logic free
    // of inferred latches.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        clks_d    = clks_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        byte_d    = byte_q;
        dv_d      = 1'b0;
        fe_d      = 1'b0;
        active_d  = active_q;
`ifdef UART_RX_PARITY_EN
        par_odd_d = par_odd_q;
        par_bit_d = par_bit_q;
        perr_d    = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                cnt_d     = 32'd0;
                bit_idx_d = 3'd0;
                if (!rx_s && (clks_calc >= MIN_CLKS)) begin
                    clks_d   = clks_calc;
                    active_d = 1'b1;
                    state_d  = START;
`ifdef UART_RX_PARITY_EN
                    par_odd_d = rx_if.i_Parity_Odd;
`endif
                end
            end

            // Re-check the line half a bit in; a high level means the
            // falling edge was a glitch and the frame is abandoned silently.
            START: begin
                if (cnt_q == half_clks) begin
                    cnt_d = 32'd0;
                    if (!rx_s) begin
                        state_d = DATA;
                    end else begin
                        active_d = 1'b0;
                        state_d  = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end

            // Counting starts mid-start-bit, so each full bit period lands
            // the sample in the middle of the next bit.
            DATA: begin
                if (bit_end) begin
                    cnt_d             = 32'd0;
                    shift_d[bit_idx_q] = rx_s;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end

`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    cnt_d     = 32'd0;
                    par_bit_d = rx_s;
                    state_d   = STOP;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
`endif

            // Framing error wins over parity: a low stop bit never reports
            // a parity mismatch.
            STOP: begin
                if (bit_end) begin
                    cnt_d = 32'd0;
                    if (rx_s) begin
                        state_d = CLEANUP;
                        if (frame_ok) begin
                            byte_d = shift_q;
                            dv_d   = 1'b1;
                        end else begin
`ifdef UART_RX_PARITY_EN
                            perr_d = 1'b1;
`endif
                        end
                    end else begin
                        fe_d    = 1'b1;
                        state_d = WAIT_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end

            // A held-low line (break) must not be read as a stream of
            // start bits; wait for it to return high first.
            WAIT_IDLE: begin
                if (rx_s) begin
                    state_d = CLEANUP;
                end
            end

            CLEANUP: begin
                active_d = 1'b0;
                state_d  = IDLE;
            end

            default: begin
                active_d = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its input from before the edge, independent of statement order.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            sync_q    <= 2'b11;
            state_q   <= IDLE;
            cnt_q     <= 32'd0;
            clks_q    <= 32'd0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'd0;
            byte_q    <= 8'd0;
            dv_q      <= 1'b0;
            fe_q      <= 1'b0;
            active_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_odd_q <= 1'b0;
            par_bit_q <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            sync_q    <= {sync_q[0], rx_if.i_Rx_Serial};
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            clks_q    <= clks_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            byte_q    <= byte_d;
            dv_q      <= dv_d;
            fe_q      <= fe_d;
            active_q  <= active_d;
`ifdef UART_RX_PARITY_EN
            par_odd_q <= par_odd_d;
            par_bit_q <= par_bit_d;
            perr_q    <= perr_d;
`endif
        end
    end

    assign rx_if.o_Rx_DV        = dv_q;
    assign rx_if.o_Rx_Byte      = byte_q;
    assign rx_if.o_Rx_Active    = active_q;
    assign rx_if.o_Rx_Frame_Err = fe_q;
`ifdef UART_RX_PARITY_EN
    assign rx_if.o_Rx_Parity_Err = perr_q;
`endif

endmodule : uart_rx
